// File: rtl/jpeg_bitbuffer_v2_if.sv
// jpeg_bitbuffer_v2_if
//   Byte-in / bit-window-out bus of the JPEG bit buffer.
//   master : byte source plus entropy decoder side (drives *_i)
//   slave  : the bit buffer itself (drives *_o)
//   Groups: img_start, inport_* (byte stream), outport_* (bit window),
//   marker_* (marker report / acknowledge).
interface jpeg_bitbuffer_v2_if #(
    parameter int DEPTH_BYTES = 8,
    parameter int OUT_W       = 32
);
    localparam int CNT_W = $clog2(DEPTH_BYTES*8) + 1;
    localparam int POP_W = $clog2(OUT_W + 1);

    logic             img_start_i;
    logic             inport_valid_i;
    logic [7:0]       inport_data_i;
    logic             inport_last_i;
    logic             inport_accept_o;
    logic [POP_W-1:0] outport_pop_i;
    logic             outport_align_i;
    logic             outport_valid_o;
    logic [OUT_W-1:0] outport_data_o;
    logic             outport_last_o;
    logic [CNT_W-1:0] outport_level_o;
    logic             marker_valid_o;
    logic [7:0]       marker_o;
    logic             marker_clr_i;

    modport master (
        output img_start_i, inport_valid_i, inport_data_i, inport_last_i,
               outport_pop_i, outport_align_i, marker_clr_i,
        input  inport_accept_o, outport_valid_o, outport_data_o,
               outport_last_o, outport_level_o, marker_valid_o, marker_o
    );

    modport slave (
        input  img_start_i, inport_valid_i, inport_data_i, inport_last_i,
               outport_pop_i, outport_align_i, marker_clr_i,
        output inport_accept_o, outport_valid_o, outport_data_o,
               outport_last_o, outport_level_o, marker_valid_o, marker_o
    );
endinterface

// File: rtl/jpeg_bitbuffer_v2.sv
// jpeg_bitbuffer_v2
//   Byte-to-bitstream buffer feeding the Huffman decoder. Accepts one byte
//   per cycle, strips JPEG stuffing (FF 00 -> FF, FF FF fill dropped), halts
//   on markers (FF xx), and presents an OUT_W-bit MSB-first look-ahead window
//   consumed by variable pops or byte alignment.
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : img_start_i, inport_*, outport_*, marker_* (see interface)
module jpeg_bitbuffer_v2 #(
    parameter int DEPTH_BYTES = 8,
    parameter int OUT_W       = 32,
    parameter bit STUFF_EN    = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    jpeg_bitbuffer_v2_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH_BYTES*8) + 1;
    localparam int POP_W = $clog2(OUT_W + 1);
    localparam int PTR_W = $clog2(DEPTH_BYTES*8);
    localparam int BP_W  = $clog2(DEPTH_BYTES);
    // one extra byte so any bit offset inside the first byte still yields OUT_W bits
    localparam int NB    = OUT_W/8 + 1;
    localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(DEPTH_BYTES*8 - 8);
    localparam logic [CNT_W-1:0] WIN_BITS = CNT_W'(OUT_W);

    logic [7:0]       ram_q [DEPTH_BYTES];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [BP_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ff_pend_q;
    logic             drain_q;
    logic             marker_q;
    logic [7:0]       marker_code_q;

    // ---------------- input byte decode ----------------
    logic       accept;
    logic       push;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ff_pend_d;
    logic       marker_set;

    always_comb begin
        accept     = (count_q <= ACC_MAX) && !marker_q;
        push       = bus.inport_valid_i && accept;
        wr_en      = 1'b0;
        wr_data    = bus.inport_data_i;
        ff_pend_d  = ff_pend_q;
        marker_set = 1'b0;
        if (push) begin
            if (!STUFF_EN) begin
                wr_en = 1'b1;
            end else if (!ff_pend_q) begin
                if (bus.inport_data_i == 8'hFF) ff_pend_d = 1'b1;
                else                            wr_en     = 1'b1;
            end else begin
                if (bus.inport_data_i == 8'h00) begin
                    wr_en     = 1'b1;
                    wr_data   = 8'hFF;
                    ff_pend_d = 1'b0;
                end else if (bus.inport_data_i != 8'hFF) begin
                    // FF FF is fill: stay pending; anything else is a marker
                    marker_set = 1'b1;
                    ff_pend_d  = 1'b0;
                end
            end
        end
    end

    // ---------------- consume side ----------------
    logic             valid;
    logic [2:0]       align_adv;
    logic [CNT_W-1:0] req;
    logic [CNT_W-1:0] consumed;

    always_comb begin
        valid     = (count_q >= WIN_BITS) || ((drain_q || marker_q) && count_q != '0);
        align_adv = 3'd0 - rd_ptr_q[2:0];
        req       = '0;
        if (valid) begin
            if (bus.outport_align_i)          req = CNT_W'(align_adv);
            else if (bus.outport_pop_i != '0) req = CNT_W'(bus.outport_pop_i);
        end
        // over-pop in the drain/marker tail empties the buffer; the read
        // pointer moves by the same saturated amount so it stays in step
        // with the write pointer when input resumes
        consumed = (req > count_q) ? count_q : req;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_BYTES; i++) ram_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ff_pend_q     <= 1'b0;
            drain_q       <= 1'b0;
            marker_q      <= 1'b0;
            marker_code_q <= '0;
        end else if (bus.img_start_i) begin
            for (int i = 0; i < DEPTH_BYTES; i++) ram_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ff_pend_q     <= 1'b0;
            drain_q       <= 1'b0;
            marker_q      <= 1'b0;
            marker_code_q <= '0;
        end else begin
            if (wr_en) begin
                ram_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + BP_W'(1);
            end
            rd_ptr_q  <= rd_ptr_q + PTR_W'(consumed);
            count_q   <= count_q + (wr_en ? CNT_W'(8) : CNT_W'(0)) - consumed;
            ff_pend_q <= ff_pend_d;
            if (push && bus.inport_last_i) drain_q <= 1'b1;
            if (marker_set) begin
                marker_q      <= 1'b1;
                marker_code_q <= bus.inport_data_i;
            end else if (bus.marker_clr_i && marker_q) begin
                marker_q <= 1'b0;
            end
        end
    end

    // ---------------- output window ----------------
    logic [OUT_W+7:0] win_raw;
    logic [OUT_W+7:0] win_sh;
    logic [BP_W-1:0]  rd_byte;
    logic [BP_W-1:0]  bidx;

    always_comb begin
        rd_byte = rd_ptr_q[PTR_W-1:3];
        bidx    = '0;
        win_raw = '0;
        for (int k = 0; k < NB; k++) begin
            bidx = rd_byte + BP_W'(k);   // wraps with the power-of-two RAM
            win_raw[OUT_W+7-8*k -: 8] = ram_q[bidx];
        end
        win_sh = win_raw << rd_ptr_q[2:0];
    end

    assign bus.inport_accept_o = accept;
    assign bus.outport_valid_o = valid;
    assign bus.outport_data_o  = win_sh[OUT_W+7 -: OUT_W];
    assign bus.outport_last_o  = drain_q && count_q != '0 && count_q <= WIN_BITS;
    assign bus.outport_level_o = count_q;
    assign bus.marker_valid_o  = marker_q;
    assign bus.marker_o        = marker_code_q;
endmodule

// File: tb/tb_jpeg_bitbuffer_v2.sv
// tb_jpeg_bitbuffer_v2
//   Directed scenarios plus randomized traffic against a bit-queue
//   reference model of the stuffing / marker / window rules.
module tb_jpeg_bitbuffer_v2;
    localparam int DEPTH = 8;
    localparam int OUT_W = 32;
    localparam int POP_W = $clog2(OUT_W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jpeg_bitbuffer_v2_if #(.DEPTH_BYTES(DEPTH), .OUT_W(OUT_W)) bus();

    jpeg_bitbuffer_v2 #(.DEPTH_BYTES(DEPTH), .OUT_W(OUT_W), .STUFF_EN(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit         mq[$];          // buffered bits, oldest first
    bit         m_ff;
    bit         m_drain;
    bit         m_marker;
    logic [7:0] m_code;

    function automatic void m_clear();
        mq.delete();
        m_ff = 0; m_drain = 0; m_marker = 0; m_code = 8'h00;
    endfunction

    function automatic bit exp_accept();
        return (mq.size() <= DEPTH*8 - 8) && !m_marker;
    endfunction

    function automatic bit exp_valid();
        return (mq.size() >= OUT_W) || ((m_drain || m_marker) && mq.size() != 0);
    endfunction

    function automatic void m_push(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endfunction

    function automatic void model_update(input bit v, input logic [7:0] d, input bit l,
                                         input int pop, input bit al, input bit clr, input bit st);
        int  sz;
        int  n;
        bit  vld, acc, mk;
        if (st) begin m_clear(); return; end
        sz  = mq.size();
        vld = exp_valid();
        acc = exp_accept();
        mk  = m_marker;
        if (vld) begin
            // stored data always ends on a byte boundary, so the bits up to
            // the next boundary are size mod 8
            n = al ? (sz % 8) : (pop > sz ? sz : pop);
            repeat (n) void'(mq.pop_front());
        end
        if (v && acc) begin
            if (l) m_drain = 1;
            if (!m_ff) begin
                if (d == 8'hFF) m_ff = 1; else m_push(d);
            end else if (d == 8'h00) begin
                m_push(8'hFF); m_ff = 0;
            end else if (d != 8'hFF) begin
                m_marker = 1; m_code = d; m_ff = 0;
            end
        end
        if (clr && mk) m_marker = 0;
    endfunction

    task automatic compare_all();
        logic [OUT_W-1:0] ew, mask;
        int sz;
        sz = mq.size();
        chk("accept", bus.inport_accept_o, exp_accept());
        chk("valid",  bus.outport_valid_o, exp_valid());
        chk("level",  bus.outport_level_o, sz);
        chk("last",   bus.outport_last_o, m_drain && sz != 0 && sz <= OUT_W);
        chk("mvalid", bus.marker_valid_o, m_marker);
        chk("mcode",  bus.marker_o, m_code);
        if (sz != 0) begin
            ew = '0; mask = '0;
            for (int i = 0; i < OUT_W && i < sz; i++) begin
                ew[OUT_W-1-i]   = mq[i];
                mask[OUT_W-1-i] = 1'b1;
            end
            chk("window", bus.outport_data_o & mask, ew);
        end
    endtask

    task automatic drive_idle();
        bus.img_start_i = 0; bus.inport_valid_i = 0; bus.inport_data_i = 0;
        bus.inport_last_i = 0; bus.outport_pop_i = 0; bus.outport_align_i = 0;
        bus.marker_clr_i = 0;
    endtask

    // one cycle: check state at negedge, drive inputs, advance model, clock
    task automatic step(input bit v, input logic [7:0] d, input bit l, input int pop,
                        input bit al, input bit clr, input bit st);
        compare_all();
        bus.img_start_i = st; bus.inport_valid_i = v; bus.inport_data_i = d;
        bus.inport_last_i = l; bus.outport_pop_i = POP_W'(pop);
        bus.outport_align_i = al; bus.marker_clr_i = clr;
        model_update(v, d, l, pop, al, clr, st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit l = 0);
        step(1, b, l, 0, 0, 0, 0);
    endtask

    task automatic idle(); step(0, 8'h00, 0, 0, 0, 0, 0); endtask
    task automatic start(); step(0, 8'h00, 0, 0, 0, 0, 1); endtask

    logic [7:0] stuff_seq [8] = '{8'hAB, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hCD};

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw;
        int guard;
        int idx;
        logic [7:0] b;
        drive_idle();
        m_clear();
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_accept", bus.inport_accept_o, 1);
        chk("rst_valid",  bus.outport_valid_o, 0);
        chk("rst_data",   bus.outport_data_o, 0);
        chk("rst_last",   bus.outport_last_o, 0);
        chk("rst_level",  bus.outport_level_o, 0);
        chk("rst_mvalid", bus.marker_valid_o, 0);
        rst = 0;
        @(negedge clk);

        // ---- basic stream and drain ----
        send(8'h11); send(8'h22); send(8'h33);
        chk("seq_valid3", bus.outport_valid_o, 0);
        send(8'h44);
        chk("seq_valid4", bus.outport_valid_o, 1);
        chk("seq_data4",  bus.outport_data_o, 32'h11223344);
        send(8'h55, 1);
        chk("seq_level5", bus.outport_level_o, 40);
        step(0, 0, 0, 4, 0, 0, 0);
        chk("seq_pop4", bus.outport_data_o[31:24], 8'h12);
        saw = 0; guard = 0;
        while (mq.size() != 0 && guard < 10) begin
            if (bus.outport_last_o && bus.outport_level_o <= 32) saw = 1;
            step(0, 0, 0, 8, 0, 0, 0);
            guard++;
        end
        chk("drain_last_seen", saw, 1);
        chk("drain_level", bus.outport_level_o, 0);
        chk("drain_valid", bus.outport_valid_o, 0);

        // ---- stuffing ----
        start();
        foreach (stuff_seq[i]) send(stuff_seq[i]);
        chk("stuff_level", bus.outport_level_o, 32);
        chk("stuff_data",  bus.outport_data_o, 32'hABFFFFCD);

        // ---- marker ----
        start();
        send(8'h12); send(8'h34); send(8'hFF); send(8'hD0);
        chk("mk_valid",  bus.marker_valid_o, 1);
        chk("mk_code",   bus.marker_o, 8'hD0);
        chk("mk_accept", bus.inport_accept_o, 0);
        chk("mk_level",  bus.outport_level_o, 16);
        chk("mk_wvalid", bus.outport_valid_o, 1);
        send(8'h56);                       // held off by the marker
        step(1, 8'h56, 0, 16, 0, 0, 0);
        chk("mk_empty", bus.outport_level_o, 0);
        step(1, 8'h56, 0, 0, 0, 1, 0);     // acknowledge
        chk("mk_cleared", bus.marker_valid_o, 0);
        send(8'h56);
        chk("mk_resume", bus.outport_level_o, 8);

        // ---- align ----
        start();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        step(0, 0, 0, 3, 0, 0, 0);
        chk("al_pop3", bus.outport_level_o, 37);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("al_level", bus.outport_level_o, 32);
        chk("al_data",  bus.outport_data_o, 32'h02030405);
        step(0, 0, 0, 5, 1, 0, 0);
        chk("al_pop_ignored", bus.outport_level_o, 32);

        // ---- full / wrap ----
        start();
        idx = 0; guard = 0; saw = 0;
        while (idx < 100 && guard < 400) begin
            b = 8'((idx * 37 + 5) % 255);  // never FF
            if (!bus.inport_accept_o && bus.outport_level_o > 56) saw = 1;
            if (exp_accept()) idx++;
            step(1, b, 0, 7, 0, 0, 0);
            guard++;
        end
        chk("wrap_done", idx, 100);
        chk("wrap_stall_seen", saw, 1);
        repeat (4) step(0, 0, 0, 7, 0, 0, 0);

        // ---- async reset mid-stream ----
        start();
        send(8'hA1); send(8'hA2); send(8'hA3);
        chk("ar_level_pre", bus.outport_level_o, 24);
        drive_idle();
        #2 rst = 1;
        #1;
        chk("ar_accept", bus.inport_accept_o, 1);
        chk("ar_valid",  bus.outport_valid_o, 0);
        chk("ar_data",   bus.outport_data_o, 0);
        chk("ar_last",   bus.outport_last_o, 0);
        chk("ar_level",  bus.outport_level_o, 0);
        chk("ar_mvalid", bus.marker_valid_o, 0);
        m_clear();
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // ---- img_start with pending marker ----
        send(8'h12); send(8'hFF); send(8'hC4);
        chk("is_mk_pre", bus.marker_valid_o, 1);
        step(1, 8'h77, 0, 4, 0, 0, 1);
        chk("is_level",  bus.outport_level_o, 0);
        chk("is_mvalid", bus.marker_valid_o, 0);
        chk("is_mcode",  bus.marker_o, 0);
        chk("is_data",   bus.outport_data_o, 0);
        chk("is_accept", bus.inport_accept_o, 1);

        // ---- randomized traffic ----
        for (int c = 0; c < 4000; c++) begin
            int r, pop;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = (r < 3) ? 8'hFF : (r == 3) ? 8'h00 : 8'($urandom);
            pop = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, OUT_W);
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 399) == 0, pop,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 299) == 0);
        end
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
